cdb_arbiter: RTL and testbench

Complete-stage arbiter directly downstream of the functional units (ALU and peers). Each cycle it selects up to `CDB_WIDTH` ready FU results in round-robin order, registers them onto the common data bus, and asserts per-FU stall to every ready FU it could not grant so that unit holds its packet. It also applies branch resolution to results in flight: it clears resolved branch bits and drops squashed results.

---
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 tb/tb_cdb_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter (with cdb_pkg packet types)
// Brief    : Round-robin complete-stage arbiter onto a CDB_WIDTH-wide common
//            data bus, with per-FU stall and branch clear/squash handling.
// Revision : 1.0
// ============================================================================

package cdb_pkg;
   localparam int BR_BITS = 4;

   typedef logic [BR_BITS-1:0] BR_MASK;

   typedef enum logic [1:0] {
      NO_TASK = 2'd0,
      CLEAR   = 2'd1,
      SQUASH  = 2'd2
   } BR_TASK;

   typedef struct packed {
      logic [5:0] dest_tag;
      BR_MASK     b_mask;
   } DECODED_VALS;

   typedef struct packed {
      DECODED_VALS decoded_vals;
      logic [31:0] result;
   } FU_PACKET;
endpackage

module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_FU    = 4,
   parameter int CDB_WIDTH = 2
)(
   input  logic                 clock,
   input  logic                 reset,
   input  FU_PACKET             fu_pack [NUM_FU],
   input  logic [NUM_FU-1:0]    fu_ready,
   input  BR_TASK               rem_br_task,
   input  BR_MASK               rem_b_id,
   output logic [NUM_FU-1:0]    fu_stall,
   output FU_PACKET             cdb_pack [CDB_WIDTH],
   output logic [CDB_WIDTH-1:0] cdb_valid
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [PTR_W-1:0]     r_rr_ptr;
   logic [PTR_W-1:0]     w_ptr_nxt;
   logic [NUM_FU-1:0]    w_kill;
   logic [NUM_FU-1:0]    w_cand;
   logic [NUM_FU-1:0]    w_grant;
   logic [PTR_W-1:0]     w_slot_idx [CDB_WIDTH];
   logic [CDB_WIDTH-1:0] w_slot_vld;
   FU_PACKET             w_slot_pack [CDB_WIDTH];
   int                   w_cnt;
   int                   w_idx;

   // A squashed result is neither a candidate nor stalled; it simply vanishes.
   generate
      for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
         assign w_kill[i] = (rem_br_task == SQUASH) &&
                            ((fu_pack[i].decoded_vals.b_mask & rem_b_id) != '0);
         assign w_cand[i] = fu_ready[i] & ~w_kill[i];
      end
   endgenerate

   always_comb begin
      w_grant    = '0;
      w_slot_vld = '0;
      w_ptr_nxt  = r_rr_ptr;
      w_cnt      = 0;
      w_idx      = 0;
      for (int k = 0; k < CDB_WIDTH; k++) begin
         w_slot_idx[k] = '0;
      end
      for (int j = 0; j < NUM_FU; j++) begin
         w_idx = int'(r_rr_ptr) + j;
         if (w_idx >= NUM_FU) begin
            w_idx = w_idx - NUM_FU;
         end
         if (w_cand[w_idx] && (w_cnt < CDB_WIDTH)) begin
            w_grant[w_idx]    = 1'b1;
            w_slot_idx[w_cnt] = PTR_W'(w_idx);
            w_slot_vld[w_cnt] = 1'b1;
            w_ptr_nxt         = (w_idx == NUM_FU - 1) ? '0 : PTR_W'(w_idx + 1);
            w_cnt             = w_cnt + 1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < CDB_WIDTH; k++) begin
         w_slot_pack[k] = '0;
         if (w_slot_vld[k]) begin
            w_slot_pack[k] = fu_pack[w_slot_idx[k]];
            if (rem_br_task == CLEAR) begin
               w_slot_pack[k].decoded_vals.b_mask =
                  fu_pack[w_slot_idx[k]].decoded_vals.b_mask & ~rem_b_id;
            end
         end
      end
   end

   assign fu_stall = reset ? (w_cand & ~w_grant) : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rr_ptr  <= '0;
         cdb_valid <= '0;
         for (int k = 0; k < CDB_WIDTH; k++) begin
            cdb_pack[k] <= '0;
         end
      end else begin
         r_rr_ptr  <= w_ptr_nxt;
         cdb_valid <= w_slot_vld;
         for (int k = 0; k < CDB_WIDTH; k++) begin
            cdb_pack[k] <= w_slot_pack[k];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter (default params).
// Revision : 1.0
// ============================================================================

module tb_cdb_arbiter;
   import cdb_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   FU_PACKET   fu_pack [4];
   logic [3:0] fu_ready;
   BR_TASK     rem_br_task;
   BR_MASK     rem_b_id;
   logic [3:0] fu_stall;
   FU_PACKET   cdb_pack [2];
   logic [1:0] cdb_valid;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   cdb_arbiter #(.NUM_FU(4), .CDB_WIDTH(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .fu_pack     (fu_pack),
      .fu_ready    (fu_ready),
      .rem_br_task (rem_br_task),
      .rem_b_id    (rem_b_id),
      .fu_stall    (fu_stall),
      .cdb_pack    (cdb_pack),
      .cdb_valid   (cdb_valid)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_masks(input BR_MASK m);
      for (int i = 0; i < 4; i++) begin
         fu_pack[i].decoded_vals.b_mask = m;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      fu_ready    = 4'b1111;
      rem_br_task = NO_TASK;
      rem_b_id    = '0;
      for (int i = 0; i < 4; i++) begin
         fu_pack[i].decoded_vals.dest_tag = 6'(i + 8);
         fu_pack[i].decoded_vals.b_mask   = '0;
         fu_pack[i].result                = 32'(32'hA0 + i);
      end

      // Reset held low
      #3;
      check("rst_stall", 64'(fu_stall), 64'h0);
      check("rst_valid", 64'(cdb_valid), 64'h0);
      check("rst_ptr", 64'(dut.r_rr_ptr), 64'h0);

      // Release between edges; ptr 0 grants FU0/FU1
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("rel_stall", 64'(fu_stall), 64'hC);
      step();
      check("rel_valid", 64'(cdb_valid), 64'h3);
      check("rel_ptr", 64'(dut.r_rr_ptr), 64'h2);
      check("rel_p0", 64'(cdb_pack[0].result), 64'hA0);
      check("rel_p1", 64'(cdb_pack[1].result), 64'hA1);
      check("rr_stall2", 64'(fu_stall), 64'h3);

      // Round robin continues: {2,3} then {0,1}
      step();
      check("rr1_p0", 64'(cdb_pack[0].result), 64'hA2);
      check("rr1_p1", 64'(cdb_pack[1].result), 64'hA3);
      check("rr1_ptr", 64'(dut.r_rr_ptr), 64'h0);
      step();
      check("rr2_p0", 64'(cdb_pack[0].result), 64'hA0);
      check("rr2_p1", 64'(cdb_pack[1].result), 64'hA1);
      check("rr2_ptr", 64'(dut.r_rr_ptr), 64'h2);

      // Single grant of FU2 moves ptr to 3
      fu_ready = 4'b0100;
      #1;
      check("one_stall", 64'(fu_stall), 64'h0);
      step();
      check("one_valid", 64'(cdb_valid), 64'h1);
      check("one_p0", 64'(cdb_pack[0].result), 64'hA2);
      check("one_p1", 64'(cdb_pack[1]), 64'h0);
      check("one_ptr", 64'(dut.r_rr_ptr), 64'h3);

      // Wrap and sparse from ptr 3
      fu_ready = 4'b0101;
      #1;
      check("wrap_stall", 64'(fu_stall), 64'h0);
      step();
      check("wrap_valid", 64'(cdb_valid), 64'h3);
      check("wrap_p0", 64'(cdb_pack[0].result), 64'hA0);
      check("wrap_p1", 64'(cdb_pack[1].result), 64'hA2);
      check("wrap_ptr", 64'(dut.r_rr_ptr), 64'h3);

      fu_ready = 4'b0000;
      step();
      check("idle_valid", 64'(cdb_valid), 64'h0);
      check("idle_p0", 64'(cdb_pack[0]), 64'h0);
      check("idle_ptr", 64'(dut.r_rr_ptr), 64'h3);

      // Squash kills FU0; FU1/FU2 granted from ptr 3
      fu_ready    = 4'b0111;
      fu_pack[0].decoded_vals.b_mask = 4'b0010;
      rem_br_task = SQUASH;
      rem_b_id    = 4'b0010;
      #1;
      check("sq_stall", 64'(fu_stall), 64'h0);
      step();
      check("sq_valid", 64'(cdb_valid), 64'h3);
      check("sq_p0", 64'(cdb_pack[0].result), 64'hA1);
      check("sq_p1", 64'(cdb_pack[1].result), 64'hA2);
      check("sq_ptr", 64'(dut.r_rr_ptr), 64'h3);

      // Clear on a single grant from ptr 3
      fu_ready    = 4'b0001;
      fu_pack[0].decoded_vals.b_mask = 4'b0110;
      rem_br_task = CLEAR;
      rem_b_id    = 4'b0100;
      step();
      check("clr_valid", 64'(cdb_valid), 64'h1);
      check("clr_mask", 64'(cdb_pack[0].decoded_vals.b_mask), 64'h2);
      check("clr_res", 64'(cdb_pack[0].result), 64'hA0);
      check("clr_tag", 64'(cdb_pack[0].decoded_vals.dest_tag), 64'h8);
      check("clr_ptr", 64'(dut.r_rr_ptr), 64'h1);

      // Clear on both slots with contention from ptr 1
      fu_ready = 4'b1111;
      set_masks(4'b0110);
      #1;
      check("clr2_stall", 64'(fu_stall), 64'h9);
      step();
      check("clr2_p0", 64'({cdb_pack[0].decoded_vals.b_mask, cdb_pack[0].result}), 64'h2_0000_00A1);
      check("clr2_p1", 64'({cdb_pack[1].decoded_vals.b_mask, cdb_pack[1].result}), 64'h2_0000_00A2);
      check("clr2_ptr", 64'(dut.r_rr_ptr), 64'h3);

      // No task: mask passes through untouched
      rem_br_task = NO_TASK;
      step();
      check("pass_p0", 64'({cdb_pack[0].decoded_vals.b_mask, cdb_pack[0].result}), 64'h6_0000_00A3);
      check("pass_p1", 64'({cdb_pack[1].decoded_vals.b_mask, cdb_pack[1].result}), 64'h6_0000_00A0);
      check("pass_valid", 64'(cdb_valid), 64'h3);

      // Asynchronous reset between edges
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("arst_valid", 64'(cdb_valid), 64'h0);
      check("arst_ptr", 64'(dut.r_rr_ptr), 64'h0);
      check("arst_stall", 64'(fu_stall), 64'h0);
      check("arst_p0", 64'(cdb_pack[0]), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
